demux_32_stream: RTL and testbench
==================================

Name: demux_32_stream

Overview:
- Inverse of the 32-bit 2:1 select mux: steers one incoming word stream to one of two output streams, chosen per word by a select bit.
- Each output has its own small FIFO with valid/ready handshake, so a stalled consumer on one side does not block traffic to the other side until that side's FIFO fills.
- Used in the datapath wherever one result must be routed to one of two consumers, for example a writeback path versus a memory store path.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 2, entries per output FIFO. Must be a power of two and at least 2.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  incoming word.
- in_sel  input  1  0 routes to output 1, 1 routes to output 2 (same polarity as the mux: op==0 selects input1).
- in_valid  input  1  in_data and in_sel are valid.
- in_ready  output  1  the word is accepted this cycle if in_valid is also high.
- out1_data  output  WIDTH  head word of FIFO 1.
- out1_valid  output  1  FIFO 1 is non-empty.
- out1_ready  input  1  consumer 1 accepts the head word.
- out2_data  output  WIDTH  head word of FIFO 2.
- out2_valid  output  1  FIFO 2 is non-empty.
- out2_ready  input  1  consumer 2 accepts the head word.

Behaviour:
- Reset, on any clk edge with rst=1, including mid-operation:
  - FIFO pointers and counts go to 0.
  - out1_valid and out2_valid go to 0.
  - Storage is cleared to 0, so out*_data read 0.
  - Any word in flight is discarded.
- in_ready:
  - Combinational: in_ready = !full(FIFO selected by in_sel).
  - Does not depend on in_valid or out*_ready.
  - No pass-through when the FIFO is full: a pop and a push in the same cycle on a full FIFO is not allowed; in_ready stays 0.
- Push: when in_valid && in_ready, in_data is written to the tail of the selected FIFO at the clock edge.
- Pop: when outN_valid && outN_ready, the head of FIFO N is removed at the clock edge.
- Latency: a word accepted at edge k appears on outN_data with outN_valid=1 after edge k, provided that FIFO was empty. There is no combinational in-to-out path.
- Simultaneous push and pop on the same non-full, non-empty FIFO: the count is unchanged, and the head and tail both advance.
- Simultaneous push to one FIFO and pop from the other: the two are independent.
- Ordering is preserved within each output. There is no ordering guarantee between the two outputs.
- Count is 0..DEPTH. full = (count == DEPTH) and empty = (count == 0). Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Stability: while outN_valid=1 and outN_ready=0, outN_data must not change.
- in_sel is sampled only when in_valid is high.

Optional Feature:
- Macro: DEMUX_32_STREAM_COUNT_EN.
- Defined:
  - Adds output ports out1_count and out2_count, each 32 bits, registered.
  - Each counts words popped from its FIFO, incrementing by 1 per pop and wrapping from 0xFFFFFFFF to 0.
  - Both reset to 0 with rst.
- Undefined: the ports and counter logic are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package:
  - constants SEL_OUT1 = 1'b0 and SEL_OUT2 = 1'b1;
  - default WIDTH = 32;
  - default DEPTH = 2.
- One sub-module, demux_fifo: a single-clock synchronous FIFO with parameters WIDTH and DEPTH, ports push/pop/data/full/empty, and the same synchronous active-high reset.
  - Instantiated twice.
  - The top level holds only the select decode, the in_ready mux and the optional counters.

Test Plan:
1. Reset and idle:
   - Stimulus: assert rst for 2 cycles with in_valid=1.
   - Response: out1_valid=0, out2_valid=0, out*_data=0, and nothing is pushed while rst=1.
2. Basic routing:
   - Stimulus: push 0xDEADBEEF with in_sel=0, then 0x12345678 with in_sel=1, with both readies held at 1.
   - Response: out1 presents 0xDEADBEEF one cycle after acceptance, out2 presents 0x12345678 one cycle after its acceptance, and each valid is high for exactly 1 cycle.
3. Backpressure and full:
   - Stimulus: out1_ready=0; push 0x1, 0x2, then 0x3 to output 1.
   - Response:
     - in_ready drops to 0 after 2 accepts.
     - out1_data holds 0x1.
     - A word with in_sel=1 is still accepted (in_ready=1).
     - Releasing out1_ready delivers 0x1 then 0x2, and 0x3 is then accepted.
4. Simultaneous push/pop with wrap:
   - Stimulus: stream 10 words 0x100..0x109 to output 2 with out2_ready=1 every cycle.
   - Response: all 10 arrive in order, the count never exceeds 1, and the pointers wrap without loss.
5. Reset mid-operation:
   - Stimulus: fill both FIFOs, then pulse rst for 1 cycle.
   - Response: both valids are 0 on the next cycle, and the next pushed word 0xA5A5A5A5 is the first word out.
6. Counters (with DEMUX_32_STREAM_COUNT_EN):
   - Stimulus: deliver 3 words on out1 and 5 on out2.
   - Response: out1_count=3 and out2_count=5.
   - Stimulus: preload via force at 0xFFFFFFFF, then one pop.
   - Response: the counter reads 0.

Source files
------------

// File: rtl/demux_32_stream_pkg.sv
// demux_32_stream_pkg: shared constants for the 1:2 stream demux and its FIFOs.
package demux_32_stream_pkg;

    // Select polarity matches the 2:1 mux: 0 picks the first port.
    localparam logic SEL_OUT1 = 1'b0;
    localparam logic SEL_OUT2 = 1'b1;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DEPTH = 2;

endpackage

// File: rtl/demux_32_stream_fifo.sv
// demux_fifo: single-clock synchronous FIFO with synchronous active-high reset.
// DEPTH must be a power of two and at least 2 so pointers wrap naturally.
module demux_fifo
    import demux_32_stream_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    // Guard here too so a stray push/pop can never corrupt pointers.
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage: write the tail on push; clear every entry on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: storage is reset here because the head word is visible on
            // the output and must read 0 after reset; pure buffers skip this.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            // NOTE: non-blocking assignments for all state so every register
            // samples pre-edge values regardless of statement order.
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy: head and tail advance independently.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/demux_32_stream.sv
// demux_32_stream: steers one valid/ready word stream to one of two buffered
// outputs chosen per word by in_sel. Optional macro DEMUX_32_STREAM_COUNT_EN
// adds per-output 32-bit pop counters (out1_count, out2_count).
module demux_32_stream
    import demux_32_stream_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
`ifdef DEMUX_32_STREAM_COUNT_EN
    output logic [31:0]      out1_count,
    output logic [31:0]      out2_count,
`endif
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out2_data,
    output logic             out2_valid,
    input  logic             out2_ready
);

    logic full1, full2, empty1, empty2;
    logic push1, push2, pop1, pop2;

    // Ready depends only on the selected FIFO, never on in_valid or the
    // consumers: no pass-through into a full FIFO.
    assign in_ready = (in_sel == SEL_OUT2) ? !full2 : !full1;

    // Select decode: route an accepted word to exactly one FIFO.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no
        // latch is inferred.
        push1 = 1'b0;
        push2 = 1'b0;
        if (in_valid && in_ready) begin
            if (in_sel == SEL_OUT2) push2 = 1'b1;
            else                    push1 = 1'b1;
        end
    end

    assign out1_valid = !empty1;
    assign out2_valid = !empty2;
    assign pop1       = out1_valid && out1_ready;
    assign pop2       = out2_valid && out2_ready;

    demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
        .clk       (clk),
        .rst       (rst),
        .push      (push1),
        .push_data (in_data),
        .pop       (pop1),
        .pop_data  (out1_data),
        .full      (full1),
        .empty     (empty1)
    );

    demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo2 (
        .clk       (clk),
        .rst       (rst),
        .push      (push2),
        .push_data (in_data),
        .pop       (pop2),
        .pop_data  (out2_data),
        .full      (full2),
        .empty     (empty2)
    );

`ifdef DEMUX_32_STREAM_COUNT_EN
    // Pop counters: one increment per delivered word, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            out1_count <= '0;
            out2_count <= '0;
        end else begin
            if (pop1) out1_count <= out1_count + 32'd1;
            if (pop2) out2_count <= out2_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_demux_32_stream.sv
// tb_demux_32_stream: directed self-checking bench for demux_32_stream.
// Inputs change 1 time unit after the rising edge; outputs are checked a
// further 1 time unit later, well away from the next edge.
module tb_demux_32_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic        in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out1_data, out2_data;
    logic        out1_valid, out2_valid;
    logic        out1_ready, out2_ready;
`ifdef DEMUX_32_STREAM_COUNT_EN
    logic [31:0] out1_count, out2_count;
`endif

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    demux_32_stream dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
`ifdef DEMUX_32_STREAM_COUNT_EN
        .out1_count (out1_count),
        .out2_count (out2_count),
`endif
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out2_data  (out2_data),
        .out2_valid (out2_valid),
        .out2_ready (out2_ready)
    );

    // Advance one rising edge and move to the input-drive point.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after changing inputs.
    task automatic settle;
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic [31:0] d);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        out1_ready = 1'b0;
        out2_ready = 1'b0;
        drive(1'b1, 1'b0, 32'hFFFF_0001);
        tick;
        tick;
        settle;
        compared++;
        if (out1_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_out1_valid: got %b want 0", out1_valid);
        end
        compared++;
        if (out2_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_out2_valid: got %b want 0", out2_valid);
        end
        compared++;
        if (out1_data !== 32'h0 || out2_data !== 32'h0) begin
            mismatched++;
            $display("FAIL reset_data: got %h/%h want 0/0", out1_data, out2_data);
        end
        // Release reset with nothing offered: FIFOs must still be empty.
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'h0);
        tick;
        settle;
        compared++;
        if (out1_valid !== 1'b0 || out2_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_no_push: got valids %b%b want 00", out1_valid, out2_valid);
        end
    endtask

    task automatic test_routing;
        out1_ready = 1'b1;
        out2_ready = 1'b1;
        drive(1'b1, 1'b0, 32'hDEAD_BEEF);
        settle;
        compared++;
        if (in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL route_ready: got %b want 1", in_ready);
        end
        tick;
        drive(1'b1, 1'b1, 32'h1234_5678);
        settle;
        compared++;
        if (out1_valid !== 1'b1 || out1_data !== 32'hDEAD_BEEF || out2_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL route_out1: got v1=%b d1=%h v2=%b want 1 deadbeef 0",
                     out1_valid, out1_data, out2_valid);
        end
        tick;
        drive(1'b0, 1'b0, 32'h0);
        settle;
        compared++;
        if (out1_valid !== 1'b0 || out2_valid !== 1'b1 || out2_data !== 32'h1234_5678) begin
            mismatched++;
            $display("FAIL route_out2: got v1=%b v2=%b d2=%h want 0 1 12345678",
                     out1_valid, out2_valid, out2_data);
        end
        tick;
        settle;
        compared++;
        if (out2_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL route_out2_once: got %b want 0", out2_valid);
        end
    endtask

    task automatic test_backpressure;
        out1_ready = 1'b0;
        out2_ready = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            drive(1'b1, 1'b0, 32'(i));
            settle;
            compared++;
            if (in_ready !== 1'b1) begin
                mismatched++;
                $display("FAIL bp_accept%0d: got %b want 1", i, in_ready);
            end
            tick;
        end
        drive(1'b1, 1'b0, 32'h3);
        settle;
        compared++;
        if (in_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL bp_full: got %b want 0", in_ready);
        end
        compared++;
        if (out1_data !== 32'h1) begin
            mismatched++;
            $display("FAIL bp_hold: got %h want 1", out1_data);
        end
        // The other side keeps flowing while output 1 is full.
        drive(1'b1, 1'b1, 32'h77);
        settle;
        compared++;
        if (in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL bp_other_ready: got %b want 1", in_ready);
        end
        tick;
        drive(1'b0, 1'b0, 32'h0);
        settle;
        compared++;
        if (out2_valid !== 1'b1 || out2_data !== 32'h77 || out1_data !== 32'h1) begin
            mismatched++;
            $display("FAIL bp_other_data: got v2=%b d2=%h d1=%h want 1 77 1",
                     out2_valid, out2_data, out1_data);
        end
        tick;
        out1_ready = 1'b1;
        settle;
        compared++;
        if (out1_valid !== 1'b1 || out1_data !== 32'h1) begin
            mismatched++;
            $display("FAIL bp_release1: got v=%b d=%h want 1 1", out1_valid, out1_data);
        end
        tick;
        drive(1'b1, 1'b0, 32'h3);
        settle;
        compared++;
        if (out1_data !== 32'h2 || in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL bp_release2: got d=%h rdy=%b want 2 1", out1_data, in_ready);
        end
        tick;
        drive(1'b0, 1'b0, 32'h0);
        settle;
        compared++;
        if (out1_valid !== 1'b1 || out1_data !== 32'h3) begin
            mismatched++;
            $display("FAIL bp_third: got v=%b d=%h want 1 3", out1_valid, out1_data);
        end
        tick;
        settle;
        compared++;
        if (out1_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL bp_drained: got %b want 0", out1_valid);
        end
    endtask

    task automatic test_stream_wrap;
        out2_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b1, 32'h100 + 32'(i));
            settle;
            // With one pop per push, occupancy stays at most 1, so never full.
            compared++;
            if (in_ready !== 1'b1) begin
                mismatched++;
                $display("FAIL stream_ready%0d: got %b want 1", i, in_ready);
            end
            if (i > 0) begin
                compared++;
                if (out2_valid !== 1'b1 || out2_data !== 32'h100 + 32'(i - 1)) begin
                    mismatched++;
                    $display("FAIL stream_word%0d: got v=%b d=%h want 1 %h",
                             i - 1, out2_valid, out2_data, 32'h100 + 32'(i - 1));
                end
            end
            tick;
        end
        drive(1'b0, 1'b0, 32'h0);
        settle;
        compared++;
        if (out2_valid !== 1'b1 || out2_data !== 32'h109) begin
            mismatched++;
            $display("FAIL stream_last: got v=%b d=%h want 1 109", out2_valid, out2_data);
        end
        tick;
        settle;
        compared++;
        if (out2_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL stream_empty: got %b want 0", out2_valid);
        end
    endtask

    task automatic test_mid_reset;
        out1_ready = 1'b0;
        out2_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, i[0], 32'hC0 + 32'(i));
            tick;
        end
        // In-flight word during reset must be discarded.
        rst = 1'b1;
        drive(1'b1, 1'b0, 32'hBAD0_BAD0);
        tick;
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'h0);
        settle;
        compared++;
        if (out1_valid !== 1'b0 || out2_valid !== 1'b0 || out1_data !== 32'h0 || out2_data !== 32'h0) begin
            mismatched++;
            $display("FAIL midrst_clear: got v=%b%b d=%h/%h want 00 0/0",
                     out1_valid, out2_valid, out1_data, out2_data);
        end
        drive(1'b1, 1'b0, 32'hA5A5_A5A5);
        tick;
        drive(1'b1, 1'b0, 32'h5A5A_5A5A);
        tick;
        drive(1'b0, 1'b0, 32'h0);
        out1_ready = 1'b1;
        settle;
        compared++;
        if (out1_valid !== 1'b1 || out1_data !== 32'hA5A5_A5A5) begin
            mismatched++;
            $display("FAIL midrst_first: got v=%b d=%h want 1 a5a5a5a5", out1_valid, out1_data);
        end
        tick;
        settle;
        compared++;
        if (out1_valid !== 1'b1 || out1_data !== 32'h5A5A_5A5A) begin
            mismatched++;
            $display("FAIL midrst_second: got v=%b d=%h want 1 5a5a5a5a", out1_valid, out1_data);
        end
        tick;
        out1_ready = 1'b0;
    endtask

`ifdef DEMUX_32_STREAM_COUNT_EN
    task automatic test_counters;
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0);
        tick;
        rst = 1'b0;
        out1_ready = 1'b1;
        out2_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, (i >= 3), 32'h200 + 32'(i));
            tick;
        end
        drive(1'b0, 1'b0, 32'h0);
        tick;
        settle;
        compared++;
        if (out1_count !== 32'd3 || out2_count !== 32'd5) begin
            mismatched++;
            $display("FAIL count_values: got %0d/%0d want 3/5", out1_count, out2_count);
        end
        force dut.out1_count = 32'hFFFF_FFFF;
        tick;
        release dut.out1_count;
        drive(1'b1, 1'b0, 32'h300);
        tick;
        drive(1'b0, 1'b0, 32'h0);
        tick;
        settle;
        compared++;
        if (out1_count !== 32'h0) begin
            mismatched++;
            $display("FAIL count_wrap: got %h want 0", out1_count);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_routing;
        test_backpressure;
        test_stream_wrap;
        test_mid_reset;
`ifdef DEMUX_32_STREAM_COUNT_EN
        test_counters;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
